// File: rtl/stream_accum_7seg_multi.sv
// stream_accum_7seg_multi: frame reducer (SUM/MIN/MAX) with sequential
// double-dabble conversion to a D-digit 7-segment word.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module stream_accum_7seg_multi #(
  parameter int W     = 4,
  parameter int N_MAX = 16,
  parameter int D     = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [$clog2(N_MAX+1)-1:0]   cfg_n,
  input  logic [1:0]                   cfg_mode,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [W-1:0]                 s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [D-1:0][6:0]            m_data,
  output logic                         m_ovf
);

  localparam int ACC_W = W + $clog2(N_MAX);
  localparam int CNT_W = $clog2(N_MAX + 1);
  localparam int BC_W  = $clog2(ACC_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(ACC_W);

  typedef enum logic [1:0] {ACCUM, CONV, OUT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, n_q;
  logic [1:0]         mode_q;
  logic [ACC_W-1:0]   acc_q;
  logic [4*D-1:0]     bcd_q;
  logic               ovf_q;
  logic [BC_W-1:0]    bit_q;
  logic               s_ready_q, m_valid_q, m_ovf_q;
  logic [D-1:0][6:0]  m_data_q;

  logic [CNT_W-1:0]   n_clamp, n_eff;
  logic [ACC_W-1:0]   s_ext, acc_d, bin_d;
  logic               first, beat, last_beat, carry_d;
  logic [4*D-1:0]     bcd_adj, bcd_d;
  logic [D-1:0][6:0]  m_data_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic               lead;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Beat qualification, frame-length clamp and next accumulator value.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    n_clamp = cfg_n;
    if (cfg_n == '0)                 n_clamp = CNT_W'(1);
    else if (cfg_n > CNT_W'(N_MAX))  n_clamp = CNT_W'(N_MAX);
    first     = (cnt_q == '0);
    n_eff     = first ? n_clamp : n_q;
    s_ext     = ACC_W'(s_data);
    acc_d     = acc_q + s_ext;
    if (first)                acc_d = s_ext;
    else if (mode_q == 2'd1)  acc_d = (s_ext < acc_q) ? s_ext : acc_q;
    else if (mode_q == 2'd2)  acc_d = (s_ext > acc_q) ? s_ext : acc_q;
    beat      = s_valid && s_ready_q;
    last_beat = (cnt_q == n_eff - CNT_W'(1));
  end

  // One double-dabble step: add 3 to digits >= 5, then shift left one bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {carry_d, bcd_d, bin_d} = {bcd_adj, acc_q, 1'b0};
  end

  // Map BCD digits to segments; dashes on overflow.
  always_comb begin
    m_data_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
`endif
    for (int i = D - 1; i >= 0; i--) begin
      if (ovf_q) m_data_d[i] = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
      else if (lead && i != 0 && bcd_q[4*i +: 4] == 4'd0) m_data_d[i] = 7'b0000000;
      else begin
        m_data_d[i] = seg7(bcd_q[4*i +: 4]);
        lead        = 1'b0;
      end
`else
      else m_data_d[i] = seg7(bcd_q[4*i +: 4]);
`endif
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: asynchronous reset clears every state register, including partial frames.
    if (!rstn) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      n_q       <= '0;
      mode_q    <= '0;
      acc_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      bit_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_ovf_q   <= 1'b0;
      m_data_q  <= {D{7'b1111110}};
    end else begin
      // NOTE: non-blocking assignments only; later assignments in this block override earlier ones.
      case (state_q)
        ACCUM: begin
          s_ready_q <= 1'b1;
          if (beat) begin
            acc_q <= acc_d;
            if (first) begin
              n_q    <= n_clamp;
              mode_q <= cfg_mode;
            end
            if (last_beat) begin
              cnt_q     <= '0;
              state_q   <= CONV;
              s_ready_q <= 1'b0;
              bcd_q     <= '0;
              ovf_q     <= 1'b0;
              bit_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        CONV: begin
          if (bit_q != BC_LAST) begin
            acc_q <= bin_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_q | carry_d;
            bit_q <= bit_q + BC_W'(1);
          end else begin
            state_q   <= OUT;
            m_valid_q <= 1'b1;
            m_data_q  <= m_data_d;
            m_ovf_q   <= ovf_q;
          end
        end
        OUT: begin
          if (m_ready) begin
            state_q   <= ACCUM;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ovf   = m_ovf_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn) !(s_ready && m_valid));
  a_out_stable: assert property (@(posedge clk) disable iff (!rstn)
                  (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_ovf)));

endmodule

// File: doc/stream_accum_7seg_multi.md
Name: stream_accum_7seg_multi

Overview:
- Streaming reducer: accepts a frame of cfg_n W-bit samples over valid/ready and computes SUM, MIN or MAX per frame.
- Converts the result to D decimal digits with a sequential double-dabble and presents them as a D-digit 7-segment word over a valid/ready master port.
- Sits between a sample source and the display driver. Generalises the fixed-N, 2-digit sum block to a runtime frame length, selectable reduction mode, D digits and overflow indication.

Parameters:
- W, 4, sample width in bits.
- N_MAX, 16, maximum frame length; cfg_n is clamped to it.
- D, 3, number of output decimal digits, at least 1.
- ACC_W (localparam), W+$clog2(N_MAX), accumulator and conversion width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- cfg_n  in  $clog2(N_MAX+1)  frame length; 0 is treated as 1, values above N_MAX are treated as N_MAX.
- cfg_mode  in  2  reduction mode: 0=SUM, 1=MIN, 2=MAX, 3=SUM.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_data  in  W  sample, unsigned.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_data  out  [D-1:0][6:0]  7-seg digits; index D-1 is the most significant. Segment order is bit6=a … bit0=g, active-high.
- m_ovf  out  1  result exceeds 10^D-1; qualified by m_valid.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_ovf=0, m_data=all 7'b1111110 (zeros), state=ACCUM, counters and accumulator 0. Reset mid-frame or mid-conversion discards all partial work. s_ready rises the first cycle after rstn deasserts.
- States:
  - ACCUM: s_ready=1, m_valid=0.
  - CONV: s_ready=0, m_valid=0.
  - OUT: s_ready=0, m_valid=1.
- Sample handshake: a beat transfers when s_valid && s_ready at a clock edge. s_data is ignored otherwise.
- First beat of a frame (count==0):
  - latches the clamped cfg_n and cfg_mode for the whole frame;
  - loads acc=s_data in all modes.
  - cfg changes mid-frame have no effect.
- Later beats:
  - SUM: acc+=s_data (cannot wrap, by ACC_W sizing).
  - MIN: acc=min(acc,s_data).
  - MAX: acc=max(acc,s_data).
- Frame completion:
  - When the beat transferring is beat number n (count==n-1), the next state is CONV and the count returns to 0.
  - s_ready drops the cycle after that last beat.
- CONV:
  - Lasts exactly ACC_W cycles.
  - Double-dabble, one shift per cycle, over D BCD digits: add-3 applied to any digit ≥5 before each shift.
  - A 1 shifted out of the top BCD digit sets a sticky ovf bit (cleared on entry to CONV).
- CONV→OUT: registers m_data from the BCD digits through the 0–9 segment table and registers m_ovf.
  - If ovf=1, every digit is 7'b0000001 (dash).
- Latency: m_valid rises ACC_W+1 clocks after the edge that accepted the last beat.
- OUT:
  - m_valid, m_data and m_ovf stay stable until m_valid && m_ready.
  - On that edge: state goes to ACCUM, m_valid=0 next cycle, s_ready=1 next cycle. m_data keeps its last value.
- No frame overlap: input is stalled for the whole of CONV and OUT.
- Segment table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other digit value displays 0000000.
- Assertions: s_ready and m_valid are never both 1; in OUT, m_data does not change while m_ready=0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: leading zero digits (from D-1 downward, stopping at the first nonzero digit) display 7'b0000000. Digit 0 is always shown. Dashes on overflow are unaffected.
- When undefined: all D digits display normally, including leading zeros.

Test Plan:
- SUM, cfg_n=10, s_data=1..10, m_ready=1 -> m_valid 9 clocks after the last beat; m_data={1111110,1011011,1011011} (055); m_ovf=0. With LEADING_ZERO_BLANK_EN: {0000000,1011011,1011011}.
- MIN cfg_n=3, data 7,3,9, then MAX cfg_n=3, data 7,3,9 -> first result 3 {1111110,1111110,1111001}, second result 9. cfg_mode changed mid-frame to MAX has no effect.
- Backpressure: m_ready=0 for 20 cycles after m_valid -> m_valid, m_data and m_ovf stay constant and s_ready=0 throughout. m_ready=1 -> s_ready=1 the following cycle.
- Overflow, D=2: SUM cfg_n=16, all 15s (240) -> m_ovf=1, m_data={0000001,0000001}. The next frame, cfg_n=1, data 5 -> m_ovf=0, shows 05.
- Boundaries: cfg_n=0 with a single beat of 9 -> result 9 after one beat. cfg_n=20 is clamped to 16 -> exactly 16 beats accepted.
- Reset mid-frame: rstn low after 4 of 10 beats -> all outputs at reset values. A fresh 10-beat frame of 1s gives 010.
